// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate truth-table checker.
// No logic; latency and backpressure are not applicable.
package gate_check_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Bit i is the gate output for input vector i = {a,b}.
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  localparam int SETTLE_W = 8;

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter; expire is high while the count equals 1.
// Load takes effect next cycle; no backpressure.
module settle_counter
  import gate_check_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == W'(1));

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all input vectors into a gate, samples after SETTLE_CYCLES and compares to EXPECTED.
// SETTLE_CYCLES+2 cycles per vector; start is ignored while busy, no other backpressure.
module truth_table_checker
  import gate_check_pkg::*;
#(
  parameter int                    N_IN          = 2,
  parameter int                    SETTLE_CYCLES = 2,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED      = TT_NOR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<N_IN)-1:0]   fail_mask,
  output logic [(1<<N_IN)-1:0]   observed,
  output logic [N_IN-1:0]        vec_idx
);

  localparam int                  NV          = 1 << N_IN;
  localparam logic [N_IN-1:0]     LAST_VEC    = N_IN'(NV - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

  state_t          state;
  logic            settle_expire;
  logic [NV-1:0]   fail_next;
  logic [NV-1:0]   obs_next;

  settle_counter #(
    .W (SETTLE_W)
  ) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (state == DRIVE),
    .load_val (SETTLE_LOAD),
    .dec      (state == SETTLE),
    .expire   (settle_expire)
  );

  assign busy = (state == DRIVE) || (state == SETTLE) || (state == SAMPLE);

  // Results including the vector being sampled this cycle, so pass sees the final sample.
  always_comb begin
    fail_next          = fail_mask;
    obs_next           = observed;
    obs_next[vec_idx]  = dut_out;
    fail_next[vec_idx] = dut_out ^ EXPECTED[vec_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dut_in    <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
      observed  <= '0;
      vec_idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            fail_mask <= '0;
            observed  <= '0;
            pass      <= 1'b0;
            vec_idx   <= '0;
            dut_in    <= '0;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          state <= (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
        end
        SETTLE: begin
          if (settle_expire) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          observed  <= obs_next;
          fail_mask <= fail_next;
          if (vec_idx == LAST_VEC) begin
            state  <= DONE;
            done   <= 1'b1;
            pass   <= ~|fail_next;
            dut_in <= '0;
          end else begin
            // dut_in moves together with vec_idx, on entry to DRIVE only.
            vec_idx <= vec_idx + 1'b1;
            dut_in  <= vec_idx + 1'b1;
            state   <= DRIVE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench: two checkers (settle 2 and settle 0) driving behavioural gate models.
module tb_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [1:0] dut_in_a, dut_in_b, vec_idx_a, vec_idx_b;
  logic       dut_out_a, dut_out_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [3:0] fail_mask_a, fail_mask_b, observed_a, observed_b;
  int         sel_a = 0, sel_b = 0;
  int         n_cmp = 0, n_bad = 0;
  logic       mon_en = 1'b0;

  typedef struct {
    logic       pass;
    logic [3:0] fm;
    logic [3:0] obs;
    int         cyc;
  } exp_t;
  exp_t sb_a[$];
  exp_t sb_b[$];

  always #5 clk = ~clk;

  // sel: 0 = NOR, 1 = stuck at 0, 2 = OR
  function automatic logic gate_fn(input int sel, input logic [1:0] v);
    case (sel)
      0:       return ~(v[1] | v[0]);
      1:       return 1'b0;
      default: return v[1] | v[0];
    endcase
  endfunction

  assign dut_out_a = gate_fn(sel_a, dut_in_a);
  assign dut_out_b = gate_fn(sel_b, dut_in_b);

  truth_table_checker dut_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_mask(fail_mask_a),
    .observed(observed_a), .vec_idx(vec_idx_a)
  );

  truth_table_checker #(.SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail_mask(fail_mask_b),
    .observed(observed_b), .vec_idx(vec_idx_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t make_exp(input int sel, input int cyc);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] v;
      v = i[1:0];
      e.obs[i] = gate_fn(sel, v);
    end
    e.fm   = e.obs ^ 4'b0001;
    e.pass = (e.fm == 4'b0000);
    e.cyc  = cyc;
    return e;
  endfunction

  // Monitors: per-cycle stimulus order while busy, scoreboard pop on done.
  int   bc_a = 0, bc_b = 0;
  logic dprev_a = 1'b0, dprev_b = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (busy_a) begin
        chk("a_dut_in", 32'(dut_in_a), bc_a / 4);
        chk("a_vec_idx", 32'(vec_idx_a), bc_a / 4);
        bc_a++;
      end else begin
        chk("a_dut_in_idle", 32'(dut_in_a), 0);
        if (done_a) begin
          chk("a_done_expected", 32'(sb_a.size() > 0), 1);
          if (sb_a.size() > 0) begin
            e = sb_a.pop_front();
            chk("a_pass", 32'(pass_a), 32'(e.pass));
            chk("a_fail_mask", 32'(fail_mask_a), 32'(e.fm));
            chk("a_observed", 32'(observed_a), 32'(e.obs));
            chk("a_busy_cycles", bc_a, e.cyc);
          end
        end
        bc_a = 0;
      end
      chk("a_done_width", 32'(dprev_a & done_a), 0);
      dprev_a = done_a;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (busy_b) begin
        chk("b_dut_in", 32'(dut_in_b), bc_b / 2);
        bc_b++;
      end else begin
        chk("b_dut_in_idle", 32'(dut_in_b), 0);
        if (done_b) begin
          chk("b_done_expected", 32'(sb_b.size() > 0), 1);
          if (sb_b.size() > 0) begin
            e = sb_b.pop_front();
            chk("b_pass", 32'(pass_b), 32'(e.pass));
            chk("b_fail_mask", 32'(fail_mask_b), 32'(e.fm));
            chk("b_observed", 32'(observed_b), 32'(e.obs));
            chk("b_busy_cycles", bc_b, e.cyc);
          end
        end
        bc_b = 0;
      end
      chk("b_done_width", 32'(dprev_b & done_b), 0);
      dprev_b = done_b;
    end
  end

  task automatic pulse_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  task automatic wait_a(input string tag);
    int n = 0;
    while (sb_a.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(sb_a.size()), 0);
    @(negedge clk);
    chk({tag, "_done_low"}, 32'(done_a), 0);
  endtask

  task automatic check_zero_a(input string tag);
    chk({tag, "_busy"}, 32'(busy_a), 0);
    chk({tag, "_done"}, 32'(done_a), 0);
    chk({tag, "_pass"}, 32'(pass_a), 0);
    chk({tag, "_fail_mask"}, 32'(fail_mask_a), 0);
    chk({tag, "_observed"}, 32'(observed_a), 0);
    chk({tag, "_vec_idx"}, 32'(vec_idx_a), 0);
    chk({tag, "_dut_in"}, 32'(dut_in_a), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_zero_a("rst_a");
    chk("rst_b_busy", 32'(busy_b), 0);
    chk("rst_b_observed", 32'(observed_b), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // rst wins over a coincident start
    @(negedge clk) begin rst = 1'b1; start_a = 1'b1; end
    @(negedge clk) begin rst = 1'b0; start_a = 1'b0; end
    chk("rst_over_start_busy", 32'(busy_a), 0);

    // 1: NOR, default settle
    sel_a = 0; sb_a.push_back(make_exp(0, 16));
    pulse_a();
    wait_a("nor");
    chk("nor_pass_hold", 32'(pass_a), 1);

    // 2: output stuck at 0
    sel_a = 1; sb_a.push_back(make_exp(1, 16));
    pulse_a();
    wait_a("zero");

    // 3: OR gate against NOR table
    sel_a = 2; sb_a.push_back(make_exp(2, 16));
    pulse_a();
    wait_a("or");
    chk("or_fail_hold", 32'(fail_mask_a), 32'hF);

    // 6: restart from DONE after a failing run clears results
    sel_a = 0; sb_a.push_back(make_exp(0, 16));
    pulse_a();
    chk("restart_fail_mask", 32'(fail_mask_a), 0);
    chk("restart_observed", 32'(observed_a), 0);
    chk("restart_pass", 32'(pass_a), 0);
    wait_a("rerun");

    // 4: zero settle, second start while busy is ignored
    sel_b = 0; sb_b.push_back(make_exp(0, 8));
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    repeat (2) @(negedge clk);
    start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    n = 0;
    while (sb_b.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("b_timeout", 32'(sb_b.size()), 0);
    repeat (4) @(negedge clk);
    chk("b_no_restart", 32'(busy_b), 0);

    // 5: reset during SAMPLE of vector 2
    sel_a = 0; sb_a.push_back(make_exp(0, 16));
    pulse_a();
    n = 0;
    while (vec_idx_a != 2'd2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_vec2", 32'(vec_idx_a), 2);
    repeat (3) @(negedge clk);
    chk("abort_in_sample_busy", 32'(busy_a), 1);
    rst = 1'b1;
    sb_a.delete();
    @(negedge clk) rst = 1'b0;
    check_zero_a("abort");
    sel_a = 0; sb_a.push_back(make_exp(0, 16));
    pulse_a();
    wait_a("post_abort");
    chk("post_abort_pass", 32'(pass_a), 1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
